// File: rtl/toy_dmem_if.sv
// RISC_TOY data-port bundle: core (master) drives requests, memory (slave) returns reads.
interface toy_dmem_if;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        DRVALID;
  logic        ADDR_ERR;

  modport master (
    output DREQ, DRW, DADDR, DWDATA,
    input  DRDATA, DRVALID, ADDR_ERR
  );

  modport slave (
    input  DREQ, DRW, DADDR, DWDATA,
    output DRDATA, DRVALID, ADDR_ERR
  );
endinterface

// File: rtl/toy_dmem_responder.sv
// Word-addressed data memory for the RISC_TOY data port: single-cycle writes,
// reads returned through an RD_LAT-deep register pipeline, sticky range error.
module toy_dmem_responder #(
  parameter int unsigned AW     = 10,
  parameter logic [29:0] BASE   = 30'h0,
  parameter int unsigned RD_LAT = 1
) (
  input  logic      CLK,
  input  logic      RSTN,
  toy_dmem_if.slave bus
);

  localparam int unsigned DW    = 32;
  localparam int unsigned WAW   = 30;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LAST  = RD_LAT - 1;

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $fatal(1, "toy_dmem_responder: RD_LAT=%0d outside 1..4", RD_LAT);
    end
  endgenerate

  logic [DW-1:0]               mem_q [DEPTH];
  logic [RD_LAT-1:0][DW-1:0]   data_q, data_d;
  logic [RD_LAT-1:0]           vld_q, vld_d;
  logic                        err_q, err_d;

  logic [WAW-1:0] idx_c;
  logic [AW-1:0]  mem_idx_c;
  logic           in_range_c;
  logic           wr_en_c;
  logic           rd_en_c;
  logic [DW-1:0]  rd_word_c;

  // Address decode; out-of-range reads fetch zero instead of aliasing.
  always_comb begin
    idx_c      = bus.DADDR - BASE;
    in_range_c = (bus.DADDR >= BASE) && ((idx_c >> AW) == '0);
    mem_idx_c  = idx_c[AW-1:0];
    wr_en_c    = bus.DREQ && bus.DRW && in_range_c;
    rd_en_c    = bus.DREQ && !bus.DRW;
    rd_word_c  = in_range_c ? mem_q[mem_idx_c] : '0;
  end

  // Read pipeline; the last stage only loads on a valid word so DRDATA holds.
  always_comb begin
    data_d    = data_q;
    vld_d     = '0;
    vld_d[0]  = rd_en_c;
    data_d[0] = rd_word_c;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    if (!vld_d[LAST]) begin
      data_d[LAST] = data_q[LAST];
    end
    err_d = err_q || (bus.DREQ && !in_range_c);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      data_q <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  // Storage is deliberately not reset so contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      mem_q[mem_idx_c] <= bus.DWDATA;
    end
  end

  assign bus.DRDATA   = data_q[LAST];
  assign bus.DRVALID  = vld_q[LAST];
  assign bus.ADDR_ERR = err_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Directed bench for toy_dmem_responder: five instances cover the latency and
// address-map variants; a scoreboard checks read data and exact return cycle.
module tb_toy_dmem_responder;

  localparam int NDUT = 5;
  localparam int LAT [NDUT] = '{1, 3, 1, 4, 2};

  logic        clk = 1'b0;
  logic        rstn     [NDUT];
  logic        dreq     [NDUT];
  logic        drw      [NDUT];
  logic [29:0] daddr    [NDUT];
  logic [31:0] dwdata   [NDUT];
  logic [31:0] drdata   [NDUT];
  logic        drvalid  [NDUT];
  logic        addr_err [NDUT];

  always #5 clk = ~clk;

  // dut0: basic/idle, dut1: RD_LAT=3, dut2: AW=4 BASE=0x100, dut3: RD_LAT=4 reset, dut4: RD_LAT=2 mixed
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    toy_dmem_if bus ();
    assign bus.DREQ    = dreq[g];
    assign bus.DRW     = drw[g];
    assign bus.DADDR   = daddr[g];
    assign bus.DWDATA  = dwdata[g];
    assign drdata[g]   = bus.DRDATA;
    assign drvalid[g]  = bus.DRVALID;
    assign addr_err[g] = bus.ADDR_ERR;

    toy_dmem_responder #(
      .AW     (g == 2 ? 4 : 10),
      .BASE   (g == 2 ? 30'h100 : 30'h0),
      .RD_LAT (g == 1 ? 3 : g == 3 ? 4 : g == 4 ? 2 : 1)
    ) u_dut (
      .CLK  (clk),
      .RSTN (rstn[g]),
      .bus  (bus)
    );
  end

  typedef struct {
    int          k;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb [$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_tests++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request in the current cycle; reads may register an expected response.
  task automatic drive(input int k, input logic rw, input logic [29:0] a,
                       input logic [31:0] d, input bit expect_resp, input logic [31:0] expd);
    exp_t e;
    dreq[k]   = 1'b1;
    drw[k]    = rw;
    daddr[k]  = a;
    dwdata[k] = d;
    if (!rw && expect_resp) begin
      e.k    = k;
      e.data = expd;
      e.due  = cyc + LAT[k];
      sb.push_back(e);
    end
    step();
    dreq[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [29:0] a, input logic [31:0] d);
    drive(k, 1'b1, a, d, 1'b0, 32'h0);
  endtask

  task automatic rd(input int k, input logic [29:0] a, input logic [31:0] expd);
    drive(k, 1'b0, a, 32'h0, 1'b1, expd);
  endtask

  task automatic rd_drop(input int k, input logic [29:0] a);
    drive(k, 1'b0, a, 32'h0, 1'b0, 32'h0);
  endtask

  // Response monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (drvalid[k] !== 1'b0) begin
        n_tests++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_valid: dut%0d drvalid=%b at cycle %0d, expected none", k, drvalid[k], cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_int("resp_dut", k, e.k);
          chk_int("resp_cycle", cyc, e.due);
          chk("resp_data", drdata[k], e.data);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rstn[k]   = 1'b0;
      dreq[k]   = 1'b0;
      drw[k]    = 1'b0;
      daddr[k]  = '0;
      dwdata[k] = '0;
    end
    step(2);
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_drdata", drdata[k], 32'h0);
      chk("reset_drvalid", 32'(drvalid[k]), 32'h0);
      chk("reset_addr_err", 32'(addr_err[k]), 32'h0);
      rstn[k] = 1'b1;
    end
    step(2);

    // Basic write-then-read, RD_LAT=1
    wr(0, 30'd5, 32'hCAFE_0001);
    rd(0, 30'd5, 32'hCAFE_0001);
    step(3);
    chk("basic_addr_err", 32'(addr_err[0]), 32'h0);

    // Idle inputs ignored while DREQ=0
    wr(0, 30'd3, 32'h0000_0033);
    for (int i = 0; i < 10; i++) begin
      drw[0]    = 1'b1;
      daddr[0]  = 30'd3;
      dwdata[0] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      step();
    end
    rd(0, 30'd3, 32'h0000_0033);
    step(3);

    // Back-to-back reads, RD_LAT=3
    for (int i = 0; i < 4; i++) wr(1, 30'(i), 32'h10 + 32'(i));
    for (int i = 0; i < 4; i++) rd(1, 30'(i), 32'h10 + 32'(i));
    step(5);
    chk("pipe_hold_drvalid", 32'(drvalid[1]), 32'h0);
    chk("pipe_hold_drdata", drdata[1], 32'h13);

    // Address range, BASE=0x100 AW=4
    wr(2, 30'h10F, 32'h0000_BEEF);
    chk("oor_err_clear", 32'(addr_err[2]), 32'h0);
    wr(2, 30'h0FF, 32'h1234_5678);
    chk("oor_err_set", 32'(addr_err[2]), 32'h1);
    rd(2, 30'h110, 32'h0);
    rd(2, 30'h10F, 32'h0000_BEEF);
    wr(2, 30'h100, 32'h0000_0100);
    rd(2, 30'h100, 32'h0000_0100);
    step(3);
    chk("oor_err_sticky", 32'(addr_err[2]), 32'h1);

    // Reset with reads in flight, RD_LAT=4
    wr(3, 30'd8, 32'hDEAD_0008);
    wr(3, 30'd9, 32'hDEAD_0009);
    wr(3, 30'd2000, 32'h0000_0BAD);
    chk("rst_err_before", 32'(addr_err[3]), 32'h1);
    rd(3, 30'd8, 32'hDEAD_0008);
    step(6);
    chk("rst_drdata_before", drdata[3], 32'hDEAD_0008);
    rd_drop(3, 30'd8);
    rd_drop(3, 30'd9);
    step(1);
    rstn[3] = 1'b0;
    #1;
    chk("rst_async_drdata", drdata[3], 32'h0);
    chk("rst_async_err", 32'(addr_err[3]), 32'h0);
    step(2);
    rstn[3] = 1'b1;
    step(6);
    chk("rst_after_drdata", drdata[3], 32'h0);
    chk("rst_after_err", 32'(addr_err[3]), 32'h0);
    rd(3, 30'd9, 32'hDEAD_0009);
    step(6);

    // Alternating write/read to one address, RD_LAT=2
    for (int i = 0; i < 8; i++) begin
      wr(4, 30'd7, 32'hA5A5_0000 + 32'(i));
      rd(4, 30'd7, 32'hA5A5_0000 + 32'(i));
    end
    step(8);

    chk_int("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
